// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2
  } fetch_state_t;

  localparam int unsigned INSN_WIDTH = 32;
  localparam int unsigned PC_INC     = 4;
  localparam logic [INSN_WIDTH-1:0] NOP_INSN = '0;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential step or PC-relative word-offset branch.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                jp,
  input  logic                cond_br,
  input  logic                alu_zero,
  input  logic [63:0]         branch_offset,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                taken
);

  logic [PC_WIDTH-1:0] w_off;

  // Offset counts words; sign-extend or truncate to the PC width before scaling.
  assign w_off   = PC_WIDTH'($signed(branch_offset));
  assign taken   = jp | (cond_br & ~alu_zero);
  assign next_pc = taken ? (pc + (w_off << 2)) : (pc + PC_WIDTH'(PC_INC));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, instruction latch.
// Optional FETCH_BRANCH_COUNT_EN adds a 32-bit taken-branch counter output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INSN_WIDTH-1:0] imem_rdata,
  output logic [INSN_WIDTH-1:0] instruction,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  jp,
  input  logic                  cond_br,
  input  logic                  alu_zero,
  input  logic [63:0]           branch_offset,
`ifdef FETCH_BRANCH_COUNT_EN
  output logic [31:0]           taken_count,
`endif
  output logic [PC_WIDTH-1:0]   pc
);

  fetch_state_t          r_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INSN_WIDTH-1:0] r_insn;
  logic [PC_WIDTH-1:0]   w_next_pc;
  logic                  w_taken;
  logic                  w_commit;

  next_pc_calc #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc            (r_pc),
    .jp            (jp),
    .cond_br       (cond_br),
    .alu_zero      (alu_zero),
    .branch_offset (branch_offset),
    .next_pc       (w_next_pc),
    .taken         (w_taken)
  );

  assign w_commit = (r_state == HOLD) && inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RESET_S;
      r_pc    <= RESET_PC;
      r_insn  <= NOP_INSN;
    end else begin
      case (r_state)
        RESET_S: r_state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            r_insn  <= imem_rdata;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            r_pc    <= w_next_pc;
            r_state <= FETCH;
          end
        end
        default: r_state <= RESET_S;
      endcase
    end
  end

`ifdef FETCH_BRANCH_COUNT_EN
  logic [31:0] r_taken_count;

  // Wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken_count <= '0;
    end else if (w_commit && w_taken) begin
      r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign taken_count = r_taken_count;
`endif

  // Handshake strobes decode straight from the state register so reset drops them at once.
  assign imem_req    = (r_state == FETCH);
  assign inst_valid  = (r_state == HOLD);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_insn;

endmodule
